// File: rtl/pipe_fwd_chain.sv
// rtl/pipe_fwd_chain.sv - in-order pipeline register chain with forwarding select and load-use interlock
module pipe_fwd_chain #(
  parameter  int DW     = 32,
  parameter  int RW     = 5,
  parameter  int NSTAGE = 3,
  parameter  int NSRC   = 2,
  localparam int SW     = $clog2(NSTAGE + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DW-1:0]          in_data,
  input  logic [RW-1:0]          in_rd,
  input  logic                   in_regwrite,
  input  logic [SW-1:0]          in_avail,
  input  logic [NSRC*RW-1:0]     in_rs,
  input  logic                   hold,
  input  logic [NSTAGE-1:0]      flush_mask,
  input  logic [NSTAGE*DW-1:0]   stage_res,
  output logic [NSTAGE-1:0]      st_valid,
  output logic [NSTAGE*DW-1:0]   st_data,
  output logic [NSTAGE*RW-1:0]   st_rd,
  output logic [NSTAGE-1:0]      st_regwrite,
  output logic [NSRC*SW-1:0]     fwd_sel,
  output logic [NSRC*DW-1:0]     fwd_data,
  output logic                   dec_stall,
  output logic [31:0]            stall_cnt
);

  // Stage k (1-based) lives at index k-1 of every per-stage array.
  logic [NSTAGE-1:0] valid_q, valid_d;
  logic [NSTAGE-1:0] regwrite_q, regwrite_d;
  logic [DW-1:0]     data_q  [NSTAGE];
  logic [DW-1:0]     data_d  [NSTAGE];
  logic [RW-1:0]     rd_q    [NSTAGE];
  logic [RW-1:0]     rd_d    [NSTAGE];
  logic [SW-1:0]     avail_q [NSTAGE];
  logic [SW-1:0]     avail_d [NSTAGE];

  logic [SW-1:0]     avail_in;
  logic [NSRC-1:0]   hazard_src;
  logic              hazard;
  logic [RW-1:0]     rs;
  logic              hit;
  int                hit_idx;
  logic [31:0]       stall_cnt_q;
  logic [31:0]       stall_cnt_d;

  // Clamp the producer's first-ready stage into 1..NSTAGE before it is stored
  always_comb begin
    avail_in = in_avail;
    if (in_avail == '0) begin
      avail_in = SW'(1);
    end else if ({1'b0, in_avail} > (SW+1)'(NSTAGE)) begin
      avail_in = SW'(NSTAGE);
    end
  end

  // Per source: youngest matching stage wins; a not-ready winner stalls rather than falling back
  always_comb begin
    fwd_sel    = '0;
    fwd_data   = '0;
    hazard_src = '0;
    rs         = '0;
    hit        = 1'b0;
    hit_idx    = 0;
    for (int i = 0; i < NSRC; i++) begin
      rs      = in_rs[i*RW +: RW];
      hit     = 1'b0;
      hit_idx = 0;
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if (valid_q[k] && regwrite_q[k] && (rd_q[k] == rs) && (rs != '0)) begin
          hit     = 1'b1;
          hit_idx = k;
        end
      end
      if (hit) begin
        if (SW'(hit_idx + 1) >= avail_q[hit_idx]) begin
          fwd_sel[i*SW +: SW]  = SW'(hit_idx + 1);
          fwd_data[i*DW +: DW] = stage_res[hit_idx*DW +: DW];
        end else begin
          hazard_src[i] = 1'b1;
        end
      end
    end
  end

  assign hazard    = in_valid & (|hazard_src);
  assign dec_stall = hazard | hold;

  // Next chain contents: freeze on hold, otherwise shift and insert a bubble on hazard; flush last
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    data_d     = data_q;
    rd_d       = rd_q;
    avail_d    = avail_q;
    if (!hold) begin
      for (int k = NSTAGE - 1; k >= 1; k--) begin
        valid_d[k]    = valid_q[k-1];
        regwrite_d[k] = regwrite_q[k-1];
        data_d[k]     = data_q[k-1];
        rd_d[k]       = rd_q[k-1];
        avail_d[k]    = avail_q[k-1];
      end
      valid_d[0]    = in_valid & ~hazard;
      regwrite_d[0] = in_regwrite;
      data_d[0]     = in_data;
      rd_d[0]       = in_rd;
      avail_d[0]    = avail_in;
    end
    valid_d = valid_d & ~flush_mask;
  end

  // Stage registers; reset wins over hold and flush
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      regwrite_q <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        data_q[k]  <= '0;
        rd_q[k]    <= '0;
        avail_q[k] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      data_q     <= data_d;
      rd_q       <= rd_d;
      avail_q    <= avail_d;
    end
  end

  // Hazard cycles are only counted when the chain actually advances; the count saturates
  assign stall_cnt_d = (hazard && !hold && (stall_cnt_q != 32'hFFFF_FFFF)) ?
                       stall_cnt_q + 32'd1 : stall_cnt_q;

  // Stall counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Flatten per-stage storage onto the packed output buses
  always_comb begin
    st_data = '0;
    st_rd   = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      st_data[k*DW +: DW] = data_q[k];
      st_rd[k*RW +: RW]   = rd_q[k];
    end
  end

  assign st_valid    = valid_q;
  assign st_regwrite = regwrite_q & valid_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_fwd_chain.sv
// tb/tb_pipe_fwd_chain.sv - directed self-checking bench for pipe_fwd_chain
module tb_pipe_fwd_chain;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic [1:0]  in_avail;
  logic [9:0]  in_rs;
  logic        hold;
  logic [2:0]  flush_mask;
  logic [95:0] stage_res;
  logic [2:0]  st_valid;
  logic [95:0] st_data;
  logic [14:0] st_rd;
  logic [2:0]  st_regwrite;
  logic [3:0]  fwd_sel;
  logic [63:0] fwd_data;
  logic        dec_stall;
  logic [31:0] stall_cnt;

  int vec;
  int miscmp;

  pipe_fwd_chain dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_rd       (in_rd),
    .in_regwrite (in_regwrite),
    .in_avail    (in_avail),
    .in_rs       (in_rs),
    .hold        (hold),
    .flush_mask  (flush_mask),
    .stage_res   (stage_res),
    .st_valid    (st_valid),
    .st_data     (st_data),
    .st_rd       (st_rd),
    .st_regwrite (st_regwrite),
    .fwd_sel     (fwd_sel),
    .fwd_data    (fwd_data),
    .dec_stall   (dec_stall),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    in_data     = '0;
    in_rd       = '0;
    in_regwrite = 1'b0;
    in_avail    = 2'd1;
    in_rs       = '0;
    hold        = 1'b0;
    flush_mask  = '0;
  endtask

  task automatic issue(input logic [31:0] d, input logic [4:0] rd, input logic [1:0] av);
    in_valid    = 1'b1;
    in_data     = d;
    in_rd       = rd;
    in_regwrite = 1'b1;
    in_avail    = av;
    in_rs       = '0;
  endtask

  task automatic consume(input logic [4:0] rs0, input logic [4:0] rs1);
    in_valid    = 1'b1;
    in_data     = '0;
    in_rd       = '0;
    in_regwrite = 1'b0;
    in_avail    = 2'd1;
    in_rs       = {rs1, rs0};
  endtask

  task automatic drain();
    idle();
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_regwrite = 1'b1; in_rd = 5'd5;
    in_avail = 2'd1; in_data = 32'hDEAD_BEEF; in_rs = '0; hold = 1'b0; flush_mask = '0;
    tick(); tick();
    vec++; if (st_valid !== 3'b000) begin miscmp++; $display("FAIL reset_valid: got %b expected %b", st_valid, 3'b000); end
    vec++; if (st_regwrite !== 3'b000) begin miscmp++; $display("FAIL reset_regwrite: got %b expected %b", st_regwrite, 3'b000); end
    vec++; if (dec_stall !== 1'b0) begin miscmp++; $display("FAIL reset_stall: got %b expected %b", dec_stall, 1'b0); end
    vec++; if (stall_cnt !== 32'd0) begin miscmp++; $display("FAIL reset_cnt: got %h expected %h", stall_cnt, 32'd0); end
    reset = 1'b0;
    idle();
  endtask

  task automatic test_alu_fwd();
    issue(32'hAAAA_0005, 5'd5, 2'd1);
    tick();
    consume(5'd5, 5'd0);
    #1;
    vec++; if (fwd_sel[1:0] !== 2'd1) begin miscmp++; $display("FAIL alu_sel0: got %0d expected %0d", fwd_sel[1:0], 1); end
    vec++; if (fwd_data[31:0] !== 32'h1234) begin miscmp++; $display("FAIL alu_data0: got %h expected %h", fwd_data[31:0], 32'h1234); end
    vec++; if (fwd_sel[3:2] !== 2'd0) begin miscmp++; $display("FAIL alu_sel1: got %0d expected %0d", fwd_sel[3:2], 0); end
    vec++; if (fwd_data[63:32] !== 32'd0) begin miscmp++; $display("FAIL alu_data1: got %h expected %h", fwd_data[63:32], 32'd0); end
    vec++; if (dec_stall !== 1'b0) begin miscmp++; $display("FAIL alu_stall: got %b expected %b", dec_stall, 1'b0); end
    vec++; if (st_data[31:0] !== 32'hAAAA_0005) begin miscmp++; $display("FAIL alu_s1data: got %h expected %h", st_data[31:0], 32'hAAAA_0005); end
    tick();
    idle();
    tick();
    vec++; if (st_valid !== 3'b110) begin miscmp++; $display("FAIL alu_valid: got %b expected %b", st_valid, 3'b110); end
    vec++; if (st_regwrite !== 3'b100) begin miscmp++; $display("FAIL alu_regwrite: got %b expected %b", st_regwrite, 3'b100); end
    vec++; if (st_rd[14:10] !== 5'd5) begin miscmp++; $display("FAIL alu_s3rd: got %0d expected %0d", st_rd[14:10], 5); end
    vec++; if (st_data[95:64] !== 32'hAAAA_0005) begin miscmp++; $display("FAIL alu_s3data: got %h expected %h", st_data[95:64], 32'hAAAA_0005); end
    tick(); tick();
    vec++; if (st_valid !== 3'b000) begin miscmp++; $display("FAIL alu_retire: got %b expected %b", st_valid, 3'b000); end
  endtask

  task automatic test_avail_clamp();
    issue(32'h0000_0009, 5'd9, 2'd0);
    tick();
    consume(5'd9, 5'd0);
    #1;
    vec++; if (fwd_sel[1:0] !== 2'd1) begin miscmp++; $display("FAIL avail0_sel: got %0d expected %0d", fwd_sel[1:0], 1); end
    vec++; if (dec_stall !== 1'b0) begin miscmp++; $display("FAIL avail0_stall: got %b expected %b", dec_stall, 1'b0); end
    drain();
  endtask

  task automatic test_load_use();
    issue(32'h0000_7777, 5'd7, 2'd2);
    tick();
    consume(5'd0, 5'd7);
    #1;
    vec++; if (dec_stall !== 1'b1) begin miscmp++; $display("FAIL lu_stall: got %b expected %b", dec_stall, 1'b1); end
    vec++; if (fwd_sel[3:2] !== 2'd0) begin miscmp++; $display("FAIL lu_sel_wait: got %0d expected %0d", fwd_sel[3:2], 0); end
    vec++; if (fwd_data[63:32] !== 32'd0) begin miscmp++; $display("FAIL lu_data_wait: got %h expected %h", fwd_data[63:32], 32'd0); end
    tick();
    vec++; if (st_valid !== 3'b010) begin miscmp++; $display("FAIL lu_bubble: got %b expected %b", st_valid, 3'b010); end
    vec++; if (stall_cnt !== 32'd1) begin miscmp++; $display("FAIL lu_cnt: got %0d expected %0d", stall_cnt, 1); end
    vec++; if (st_rd[9:5] !== 5'd7) begin miscmp++; $display("FAIL lu_s2rd: got %0d expected %0d", st_rd[9:5], 7); end
    vec++; if (dec_stall !== 1'b0) begin miscmp++; $display("FAIL lu_release: got %b expected %b", dec_stall, 1'b0); end
    vec++; if (fwd_sel[3:2] !== 2'd2) begin miscmp++; $display("FAIL lu_sel: got %0d expected %0d", fwd_sel[3:2], 2); end
    vec++; if (fwd_data[63:32] !== 32'h2222_0002) begin miscmp++; $display("FAIL lu_data: got %h expected %h", fwd_data[63:32], 32'h2222_0002); end
    tick();
    vec++; if (st_valid !== 3'b101) begin miscmp++; $display("FAIL lu_after: got %b expected %b", st_valid, 3'b101); end
    vec++; if (stall_cnt !== 32'd1) begin miscmp++; $display("FAIL lu_cnt_hold: got %0d expected %0d", stall_cnt, 1); end
    drain();
  endtask

  task automatic test_youngest();
    issue(32'h31, 5'd3, 2'd1); tick();
    issue(32'h00, 5'd0, 2'd1); tick();
    issue(32'h33, 5'd3, 2'd1); tick();
    consume(5'd3, 5'd0);
    #1;
    vec++; if (fwd_sel[1:0] !== 2'd1) begin miscmp++; $display("FAIL young_sel: got %0d expected %0d", fwd_sel[1:0], 1); end
    vec++; if (fwd_data[31:0] !== 32'h1234) begin miscmp++; $display("FAIL young_data: got %h expected %h", fwd_data[31:0], 32'h1234); end
    vec++; if (fwd_sel[3:2] !== 2'd0) begin miscmp++; $display("FAIL x0_sel: got %0d expected %0d", fwd_sel[3:2], 0); end
    vec++; if (fwd_data[63:32] !== 32'd0) begin miscmp++; $display("FAIL x0_data: got %h expected %h", fwd_data[63:32], 32'd0); end
    vec++; if (dec_stall !== 1'b0) begin miscmp++; $display("FAIL young_stall: got %b expected %b", dec_stall, 1'b0); end
    drain();
    issue(32'h61, 5'd6, 2'd1); tick();
    issue(32'h63, 5'd6, 2'd3); tick();
    consume(5'd6, 5'd0);
    #1;
    vec++; if (dec_stall !== 1'b1) begin miscmp++; $display("FAIL nofb_stall: got %b expected %b", dec_stall, 1'b1); end
    vec++; if (fwd_sel[1:0] !== 2'd0) begin miscmp++; $display("FAIL nofb_sel: got %0d expected %0d", fwd_sel[1:0], 0); end
    vec++; if (fwd_data[31:0] !== 32'd0) begin miscmp++; $display("FAIL nofb_data: got %h expected %h", fwd_data[31:0], 32'd0); end
    drain();
  endtask

  task automatic test_hold_flush();
    issue(32'hA1, 5'd10, 2'd1); tick();
    issue(32'hB1, 5'd11, 2'd1); tick();
    issue(32'hC1, 5'd12, 2'd2); tick();
    consume(5'd12, 5'd0);
    hold = 1'b1;
    flush_mask = 3'b010;
    #1;
    vec++; if (dec_stall !== 1'b1) begin miscmp++; $display("FAIL hold_stall: got %b expected %b", dec_stall, 1'b1); end
    for (int c = 0; c < 2; c++) begin
      tick();
      vec++; if (st_valid !== 3'b101) begin miscmp++; $display("FAIL hold_valid[%0d]: got %b expected %b", c, st_valid, 3'b101); end
      vec++; if (st_data !== {32'hA1, 32'hB1, 32'hC1}) begin miscmp++; $display("FAIL hold_data[%0d]: got %h expected %h", c, st_data, {32'hA1, 32'hB1, 32'hC1}); end
      vec++; if (stall_cnt !== 32'd1) begin miscmp++; $display("FAIL hold_cnt[%0d]: got %0d expected %0d", c, stall_cnt, 1); end
    end
    in_valid = 1'b0;
    #1;
    vec++; if (dec_stall !== 1'b1) begin miscmp++; $display("FAIL hold_only_stall: got %b expected %b", dec_stall, 1'b1); end
    idle();
    tick();
    vec++; if (st_valid !== 3'b010) begin miscmp++; $display("FAIL unhold_valid: got %b expected %b", st_valid, 3'b010); end
    vec++; if (st_data[63:32] !== 32'hC1) begin miscmp++; $display("FAIL unhold_s2data: got %h expected %h", st_data[63:32], 32'hC1); end
    drain();
  endtask

  task automatic test_saturate_reset();
    idle();
    force dut.stall_cnt_d = 32'hFFFF_FFFE;
    tick();
    release dut.stall_cnt_d;
    #1;
    vec++; if (stall_cnt !== 32'hFFFF_FFFE) begin miscmp++; $display("FAIL sat_preset: got %h expected %h", stall_cnt, 32'hFFFF_FFFE); end
    issue(32'h88, 5'd8, 2'd3);
    tick();
    consume(5'd8, 5'd0);
    #1;
    vec++; if (dec_stall !== 1'b1) begin miscmp++; $display("FAIL sat_stall1: got %b expected %b", dec_stall, 1'b1); end
    tick();
    vec++; if (stall_cnt !== 32'hFFFF_FFFF) begin miscmp++; $display("FAIL sat_cnt1: got %h expected %h", stall_cnt, 32'hFFFF_FFFF); end
    vec++; if (dec_stall !== 1'b1) begin miscmp++; $display("FAIL sat_stall2: got %b expected %b", dec_stall, 1'b1); end
    tick();
    vec++; if (stall_cnt !== 32'hFFFF_FFFF) begin miscmp++; $display("FAIL sat_nowrap: got %h expected %h", stall_cnt, 32'hFFFF_FFFF); end
    vec++; if (dec_stall !== 1'b0) begin miscmp++; $display("FAIL sat_ready: got %b expected %b", dec_stall, 1'b0); end
    vec++; if (fwd_sel[1:0] !== 2'd3) begin miscmp++; $display("FAIL sat_sel3: got %0d expected %0d", fwd_sel[1:0], 3); end
    vec++; if (fwd_data[31:0] !== 32'h3333_0003) begin miscmp++; $display("FAIL sat_data3: got %h expected %h", fwd_data[31:0], 32'h3333_0003); end
    drain();
    issue(32'h89, 5'd8, 2'd3);
    tick();
    consume(5'd8, 5'd0);
    hold = 1'b1;
    #1;
    vec++; if (dec_stall !== 1'b1) begin miscmp++; $display("FAIL rst_pre_stall: got %b expected %b", dec_stall, 1'b1); end
    reset = 1'b1;
    tick();
    vec++; if (st_valid !== 3'b000) begin miscmp++; $display("FAIL rst_mid_valid: got %b expected %b", st_valid, 3'b000); end
    vec++; if (stall_cnt !== 32'd0) begin miscmp++; $display("FAIL rst_mid_cnt: got %h expected %h", stall_cnt, 32'd0); end
    hold = 1'b0;
    #1;
    vec++; if (dec_stall !== 1'b0) begin miscmp++; $display("FAIL rst_mid_stall: got %b expected %b", dec_stall, 1'b0); end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    vec    = 0;
    miscmp = 0;
    stage_res = {32'h3333_0003, 32'h2222_0002, 32'h0000_1234};
    test_reset();
    test_alu_fwd();
    test_avail_clamp();
    test_load_use();
    test_youngest();
    test_hold_flush();
    test_saturate_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
